// File: rtl/key_conditioner.sv
// key_conditioner: synchronise and debounce active-low KEY buttons.
// Optional auto-repeat of key_press on held keys: define KEY_AUTOREPEAT_EN.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  localparam logic [CNT_W-1:0] TERM =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] pressed;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] deb_press;
  logic [NUM_KEYS-1:0] rpt_hit;

  // Two-flop synchroniser; pressed is 1 while a key is held down
  always_comb begin
    sync1_d = KEY;
    sync2_d = sync1_q;
    pressed = ~sync2_q;
  end

  // Count consecutive disagreements; accept the new level at terminal count
  always_comb begin
    level_d   = level_q;
    deb_press = '0;
    release_d = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      cnt_d[k] = '0;
      if (pressed[k] != level_q[k]) begin
        if (cnt_q[k] == TERM) begin
          level_d[k]   = pressed[k];
          deb_press[k] = pressed[k];
          release_d[k] = ~pressed[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_W = 25;
  localparam logic [RPT_W-1:0] RPT_TERM =
    RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD =
    RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RPT_W-1:0] rpt_q [NUM_KEYS];
  logic [RPT_W-1:0] rpt_d [NUM_KEYS];

  // Hold timer runs only while the key stays accepted; dies on release edge
  always_comb begin
    rpt_hit = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      rpt_d[k] = '0;
      if (level_q[k] && level_d[k]) begin
        if (rpt_q[k] == RPT_TERM) begin
          rpt_hit[k] = 1'b1;
          rpt_d[k]   = RPT_RELOAD;
        end else begin
          rpt_d[k] = rpt_q[k] + 1'b1;
        end
      end
    end
  end

  // Repeat timer registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < NUM_KEYS; k++) rpt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) rpt_q[k] <= rpt_d[k];
    end
  end
`else
  assign rpt_hit = '0;
`endif

  // Press strobe from either an accepted press or a repeat tick
  always_comb press_d = deb_press | rpt_hit;

  // Synchroniser, debounce and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int k = 0; k < NUM_KEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed and random checks of key_conditioner
// against a history-based reference model.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DC = 8;
  localparam int CW = 4;
  localparam int RD = 40;
  localparam int RP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_level, key_press, key_release;

  int checks = 0;
  int failures = 0;

  key_conditioner #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DC), .CNT_W(CW),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference model: pressed samples two edges late; a level flips once
  // DC consecutive delayed samples disagree with it.
  logic [NK-1:0] mhist[$];
  logic [NK-1:0] m_s, mlevel, mpress, mrel;
  int mrun[NK];
  int mhold[NK];
  bit acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mhist.delete();
      mlevel = '0; mpress = '0; mrel = '0;
      for (int k = 0; k < NK; k++) begin
        mrun[k] = 0; mhold[k] = 0;
      end
    end else begin
      m_s = (mhist.size() >= 2) ? mhist[mhist.size()-2] : '0;
      mpress = '0; mrel = '0;
      for (int k = 0; k < NK; k++) begin
        acc = 1'b0;
        if (m_s[k] != mlevel[k]) begin
          mrun[k]++;
          if (mrun[k] == DC) begin
            acc = 1'b1;
            mrun[k] = 0;
            mlevel[k] = m_s[k];
            if (m_s[k]) begin
              mpress[k] = 1'b1; mhold[k] = 0;
            end else begin
              mrel[k] = 1'b1;
            end
          end
        end else begin
          mrun[k] = 0;
        end
`ifdef KEY_AUTOREPEAT_EN
        if (mlevel[k] && !acc) begin
          mhold[k]++;
          if (mhold[k] >= RD && (mhold[k] - RD) % RP == 0)
            mpress[k] = 1'b1;
        end
`endif
      end
      mhist.push_back(~key);
      if (mhist.size() > 3) void'(mhist.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    logic [NK-1:0] el, ep;
    key = 4'h0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== 12'h0) begin
      failures++;
      $display("FAIL reset_async got %b/%b/%b exp 0",
               key_level, key_press, key_release);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      el = (e >= 10) ? 4'hF : 4'h0;
      ep = (e == 10) ? 4'hF : 4'h0;
      checks++;
      if (key_level !== el || key_press !== ep
          || key_release !== 4'h0) begin
        failures++;
        $display("FAIL reset_latency e=%0d got %b/%b/%b exp %b/%b/0",
                 e, key_level, key_press, key_release, el, ep);
      end
      checks++;
      if ({key_level, key_press, key_release}
          !== {mlevel, mpress, mrel}) begin
        failures++;
        $display("FAIL reset_model e=%0d got %b/%b/%b exp %b/%b/%b",
                 e, key_level, key_press, key_release,
                 mlevel, mpress, mrel);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== 12'h0) begin
      failures++;
      $display("FAIL reset_midrun got %b/%b/%b exp 0",
               key_level, key_press, key_release);
    end
    key = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean();
    logic [NK-1:0] el, ep, er;
    key = 4'b1101;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      el = (e >= 10) ? 4'b0010 : 4'b0000;
      ep = (e == 10) ? 4'b0010 : 4'b0000;
      checks++;
      if (key_level !== el || key_press !== ep
          || key_release !== 4'h0) begin
        failures++;
        $display("FAIL clean_press e=%0d got %b/%b/%b exp %b/%b/0",
                 e, key_level, key_press, key_release, el, ep);
      end
    end
    key = 4'hF;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      el = (e >= 10) ? 4'b0000 : 4'b0010;
      er = (e == 10) ? 4'b0010 : 4'b0000;
      checks++;
      if (key_level !== el || key_press !== 4'h0
          || key_release !== er) begin
        failures++;
        $display("FAIL clean_release e=%0d got %b/%b/%b exp %b/0/%b",
                 e, key_level, key_press, key_release, el, er);
      end
      checks++;
      if ({key_level, key_press, key_release}
          !== {mlevel, mpress, mrel}) begin
        failures++;
        $display("FAIL clean_model e=%0d got %b/%b/%b exp %b/%b/%b",
                 e, key_level, key_press, key_release,
                 mlevel, mpress, mrel);
      end
    end
  endtask

  task automatic test_bounce();
    int npress = 0;
    int pedge = -1;
    bit low;
    for (int i = 0; i < 30; i++) begin
      low = (i < 5) || (i >= 7 && i < 12) || (i >= 13);
      key[2] = ~low;
      @(negedge clk);
      if (key_press[2]) begin
        npress++; pedge = i + 1;
      end
      checks++;
      if ({key_level, key_press, key_release}
          !== {mlevel, mpress, mrel}) begin
        failures++;
        $display("FAIL bounce_model i=%0d got %b/%b/%b exp %b/%b/%b",
                 i, key_level, key_press, key_release,
                 mlevel, mpress, mrel);
      end
    end
    checks++;
    if (npress !== 1 || pedge !== 23) begin
      failures++;
      $display("FAIL bounce_press count=%0d edge=%0d exp 1 at 23",
               npress, pedge);
    end
    key = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 25; i++) begin
      key[3] = (i < 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      checks++;
      if ({key_level, key_press, key_release} !== 12'h0) begin
        failures++;
        $display("FAIL glitch i=%0d got %b/%b/%b exp 0/0/0",
                 i, key_level, key_press, key_release);
      end
    end
  endtask

  task automatic test_simul_reset();
    logic [NK-1:0] pv = '0;
    int pe = -1;
    key = 4'b1100;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (key_press != 4'h0 && pe < 0) begin
        pv = key_press; pe = e;
      end
    end
    checks++;
    if (pv !== 4'b0011 || pe !== 10) begin
      failures++;
      $display("FAIL simul_press got %b at %0d exp 0011 at 10",
               pv, pe);
    end
    key = 4'hF;
    repeat (12) @(negedge clk);
    key = 4'b1110;
    for (int e = 1; e <= 5; e++) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_level, key_press, key_release} !== 12'h0) begin
      failures++;
      $display("FAIL midcount_reset got %b/%b/%b exp 0",
               key_level, key_press, key_release);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      checks++;
      if (key_press !== ((e == 10) ? 4'b0001 : 4'b0000)
          || key_release !== 4'h0) begin
        failures++;
        $display("FAIL repress e=%0d got prs=%b rel=%b",
                 e, key_press, key_release);
      end
    end
    key = 4'hF;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_hold();
    logic [NK-1:0] ep;
    int nrel = 0;
    key = 4'b1110;
    repeat (10) @(negedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
`ifdef KEY_AUTOREPEAT_EN
      ep = (c >= RD && (c - RD) % RP == 0) ? 4'b0001 : 4'b0000;
`else
      ep = 4'b0000;
`endif
      checks++;
      if (key_press !== ep || key_level !== 4'b0001) begin
        failures++;
        $display("FAIL hold c=%0d got lvl=%b prs=%b exp 0001/%b",
                 c, key_level, key_press, ep);
      end
    end
    key = 4'hF;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (key_release[0]) nrel++;
      checks++;
      if (key_press !== 4'h0) begin
        failures++;
        $display("FAIL hold_release_press e=%0d got %b exp 0000",
                 e, key_press);
      end
    end
    checks++;
    if (nrel !== 1 || key_level !== 4'h0) begin
      failures++;
      $display("FAIL hold_release count=%0d lvl=%b exp 1/0000",
               nrel, key_level);
    end
  endtask

  task automatic test_random();
    int rem[NK];
    for (int k = 0; k < NK; k++) rem[k] = 0;
    for (int c = 0; c < 700; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          key[k] = ~key[k];
          rem[k] = ($urandom_range(0, 9) == 0) ? 60
                   : $urandom_range(1, 14);
        end
        rem[k]--;
      end
      if (c == 350) begin
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
      checks++;
      if ({key_level, key_press, key_release}
          !== {mlevel, mpress, mrel}) begin
        failures++;
        $display("FAIL random c=%0d got %b/%b/%b exp %b/%b/%b",
                 c, key_level, key_press, key_release,
                 mlevel, mpress, mrel);
      end
      checks++;
      if ((key_press & key_release) !== 4'h0) begin
        failures++;
        $display("FAIL random_both c=%0d got prs=%b rel=%b",
                 c, key_press, key_release);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_glitch();
    test_simul_reset();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
